// File: rtl/regas_pkg.sv
// Shared constants for the irrigation-status display: channel codes, glyphs
// and the counter-width helper used by the scanning logic.
package regas_pkg;

  localparam int SEG_W = 7;

  // Channel code is {gotejamento, aspersao}.
  typedef enum logic [1:0] {
    COD_NENHUM      = 2'b00,
    COD_ASPERSAO    = 2'b01,
    COD_GOTEJAMENTO = 2'b10,
    COD_INVALIDO    = 2'b11
  } codigo_e;

  // Segment order is {G,F,E,D,C,B,A}, active-high.
  localparam logic [SEG_W-1:0] GLIFO_NENHUM      = 7'h3F;
  localparam logic [SEG_W-1:0] GLIFO_GOTEJAMENTO = 7'h46;
  localparam logic [SEG_W-1:0] GLIFO_ASPERSAO    = 7'h08;
  localparam logic [SEG_W-1:0] GLIFO_INVALIDO    = 7'h40;
  localparam logic [SEG_W-1:0] GLIFO_APAGADO     = 7'h00;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glifo_rega.sv
// Combinational decoder from a channel code plus blink phase to a 7-segment
// glyph; only the invalid code blinks.
module glifo_rega
  import regas_pkg::*;
(
  input  codigo_e           codigo_i,
  input  logic              fase_i,
  output logic [SEG_W-1:0]  glifo_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    glifo_o = GLIFO_NENHUM;
    unique case (codigo_i)
      COD_NENHUM:      glifo_o = GLIFO_NENHUM;
      COD_GOTEJAMENTO: glifo_o = GLIFO_GOTEJAMENTO;
      COD_ASPERSAO:    glifo_o = GLIFO_ASPERSAO;
      COD_INVALIDO:    glifo_o = fase_i ? GLIFO_APAGADO : GLIFO_INVALIDO;
      default:         glifo_o = GLIFO_NENHUM;
    endcase
  end

endmodule

// File: rtl/display_rega_multi.sv
// Multiplexed 7-segment display of per-channel irrigation status, with
// input synchronisation, frame-consistent snapshots, blink and error flags.
module display_rega_multi
  import regas_pkg::*;
#(
  parameter int CANAIS        = 4,
  parameter int DIV_VARREDURA = 50000,
  parameter int DIV_PISCA     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CANAIS-1:0] gotejamento,
  input  logic [CANAIS-1:0] aspersao,
  input  logic              habilita,
  input  logic              limpa_erro,
  output logic [SEG_W-1:0]  seg,
  output logic [CANAIS-1:0] an,
  output logic              erro_ativo,
  output logic              erro_retido
);

  localparam int IDX_W = largura(CANAIS);
  localparam int PRE_W = largura(DIV_VARREDURA);
  localparam int FRM_W = largura(DIV_PISCA);

  localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(CANAIS - 1);
  localparam logic [PRE_W-1:0] PRE_ULT = PRE_W'(DIV_VARREDURA - 1);
  localparam logic [FRM_W-1:0] FRM_ULT = FRM_W'(DIV_PISCA - 1);

  logic [CANAIS-1:0] got_meta_q, got_sync_q, asp_meta_q, asp_sync_q;
  logic [CANAIS-1:0] snap_got_q, snap_got_d, snap_asp_q, snap_asp_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              fase_q, fase_d;
  logic [CANAIS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              erro_ativo_q, erro_ativo_d;
  logic              erro_retido_q, erro_retido_d;
  logic              tick, wrap;
  codigo_e           codigo_atual;
  logic [SEG_W-1:0]  glifo_atual;

  // Two-flop synchronisers for the request inputs, which arrive unclocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_meta_q <= '0;
      got_sync_q <= '0;
      asp_meta_q <= '0;
      asp_sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two stages.
      got_meta_q <= gotejamento;
      got_sync_q <= got_meta_q;
      asp_meta_q <= aspersao;
      asp_sync_q <= asp_meta_q;
    end
  end

  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    fase_d     = fase_q;
    snap_got_d = snap_got_q;
    snap_asp_d = snap_asp_q;
    tick       = 1'b0;
    wrap       = 1'b0;

    if (!habilita) begin
      presc_d    = '0;
      idx_d      = '0;
      frame_d    = '0;
      snap_got_d = got_sync_q;
      snap_asp_d = asp_sync_q;
    end else begin
      tick    = (presc_q == PRE_ULT);
      wrap    = tick && (idx_q == IDX_ULT);
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      // Data changes only at frame boundaries, so a frame never mixes states.
      if (wrap) begin
        snap_got_d = got_sync_q;
        snap_asp_d = asp_sync_q;
        frame_d    = (frame_q == FRM_ULT) ? '0 : frame_q + 1'b1;
        if (frame_q == FRM_ULT) fase_d = ~fase_q;
      end
    end

    an_d  = '1;
    seg_d = GLIFO_APAGADO;
    if (habilita) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glifo_atual;
    end

    erro_ativo_d  = |(snap_got_q & snap_asp_q);
    erro_retido_d = erro_ativo_q | (erro_retido_q & ~limpa_erro);
  end

  assign codigo_atual = codigo_e'({snap_got_q[idx_q], snap_asp_q[idx_q]});

  glifo_rega u_glifo (
    .codigo_i (codigo_atual),
    .fase_i   (fase_q),
    .glifo_o  (glifo_atual)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_got_q    <= '0;
      snap_asp_q    <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      fase_q        <= 1'b0;
      an_q          <= '1;
      seg_q         <= GLIFO_APAGADO;
      erro_ativo_q  <= 1'b0;
      erro_retido_q <= 1'b0;
    end else begin
      snap_got_q    <= snap_got_d;
      snap_asp_q    <= snap_asp_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      fase_q        <= fase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      erro_ativo_q  <= erro_ativo_d;
      erro_retido_q <= erro_retido_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign erro_ativo  = erro_ativo_q;
  assign erro_retido = erro_retido_q;

endmodule

// File: tb/tb_display_rega_multi.sv
// Directed bench: CANAIS=4, DIV_VARREDURA=4, DIV_PISCA=2 main instance plus a
// single-channel instance for the degenerate scan.
module tb_display_rega_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gote, asp;
  logic       habilita, limpa_erro;
  logic [6:0] seg;
  logic [3:0] an;
  logic       erro_ativo, erro_retido;

  logic [0:0] gote1, asp1;
  logic [6:0] seg1;
  logic [0:0] an1;
  logic       ea1, er1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_rega_multi #(.CANAIS(4), .DIV_VARREDURA(4), .DIV_PISCA(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gotejamento (gote),
    .aspersao    (asp),
    .habilita    (habilita),
    .limpa_erro  (limpa_erro),
    .seg         (seg),
    .an          (an),
    .erro_ativo  (erro_ativo),
    .erro_retido (erro_retido)
  );

  display_rega_multi #(.CANAIS(1), .DIV_VARREDURA(2), .DIV_PISCA(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .gotejamento (gote1),
    .aspersao    (asp1),
    .habilita    (habilita),
    .limpa_erro  (limpa_erro),
    .seg         (seg1),
    .an          (an1),
    .erro_ativo  (ea1),
    .erro_retido (er1)
  );

  typedef struct {
    int         adv;
    bit         limpa;
    logic [3:0] g;
    logic [3:0] a;
    bit         hab;
    logic [3:0] an;
    logic [6:0] seg;
    bit         ea;
    bit         er;
    bit         an1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input bit e_ea, input bit e_er, input bit e_an1);
    check({tag, " an"},          32'(an),          32'(e_an));
    check({tag, " seg"},         32'(seg),         32'(e_seg));
    check({tag, " erro_ativo"},  32'(erro_ativo),  32'(e_ea));
    check({tag, " erro_retido"}, 32'(erro_retido), 32'(e_er));
    check({tag, " an1"},         32'(an1),         32'(e_an1));
  endtask

  initial begin
    // Comments give the rising-edge count since reset release at which each
    // vector is sampled; index i is shown after edges 16f+4i+1 .. 16f+4i+4.
    //                 adv  lim  g        a        hab  an       seg    ea er an1
    vecs.push_back('{  1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h3F, 0, 0, 0}); // E1
    vecs.push_back('{  4, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1101, 7'h3F, 0, 0, 0}); // E5
    vecs.push_back('{  4, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1011, 7'h3F, 0, 0, 0}); // E9
    vecs.push_back('{  4, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0111, 7'h3F, 0, 0, 0}); // E13
    vecs.push_back('{  4, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h3F, 0, 0, 0}); // E17
    vecs.push_back('{  4, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1101, 7'h3F, 0, 0, 0}); // E21 mid-frame
    vecs.push_back('{  4, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1011, 7'h3F, 0, 0, 0}); // E25
    vecs.push_back('{  8, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1110, 7'h3F, 0, 0, 0}); // E33
    vecs.push_back('{  4, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1101, 7'h08, 0, 0, 0}); // E37
    vecs.push_back('{  4, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b1011, 7'h46, 0, 0, 0}); // E41
    vecs.push_back('{  4, 1'b0, 4'b0100, 4'b0010, 1'b1, 4'b0111, 7'h3F, 0, 0, 0}); // E45
    vecs.push_back('{  4, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1110, 7'h3F, 1, 0, 0}); // E49
    vecs.push_back('{  1, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1110, 7'h3F, 1, 1, 0}); // E50
    vecs.push_back('{  3, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1101, 7'h3F, 1, 1, 0}); // E53
    vecs.push_back('{  8, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0111, 7'h00, 1, 1, 0}); // E61 blink off
    vecs.push_back('{ 16, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0111, 7'h40, 1, 1, 0}); // E77 blink on
    vecs.push_back('{ 32, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0111, 7'h00, 1, 1, 0}); // E109
    vecs.push_back('{  1, 1'b1, 4'b1000, 4'b1000, 1'b1, 4'b0111, 7'h00, 1, 1, 0}); // E110 set wins
    vecs.push_back('{  3, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1110, 7'h3F, 1, 1, 0}); // E113
    vecs.push_back('{ 15, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0111, 7'h00, 1, 1, 0}); // E128
    vecs.push_back('{  1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h3F, 0, 1, 0}); // E129
    vecs.push_back('{  1, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h3F, 0, 0, 0}); // E130 clear
    vecs.push_back('{ 11, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0111, 7'h3F, 0, 0, 0}); // E141
    vecs.push_back('{  1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 7'h00, 0, 0, 1}); // E142 disabled
    vecs.push_back('{  4, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b1111, 7'h00, 1, 0, 1}); // E146
    vecs.push_back('{  1, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b1111, 7'h00, 1, 1, 1}); // E147
    vecs.push_back('{  1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h40, 1, 1, 0}); // E148 enable
    vecs.push_back('{  3, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1110, 7'h40, 1, 1, 0}); // E151
    vecs.push_back('{  1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1101, 7'h3F, 1, 1, 0}); // E152
    vecs.push_back('{  5, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1011, 7'h3F, 1, 1, 0}); // E157 index 2

    rst_n      = 1'b0;
    gote       = '0;
    asp        = '0;
    gote1      = '0;
    asp1       = '0;
    habilita   = 1'b1;
    limpa_erro = 1'b0;

    repeat (2) @(negedge clk);
    check_all("reset", 4'b1111, 7'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      gote     = vecs[i].g;
      asp      = vecs[i].a;
      habilita = vecs[i].hab;
      for (int c = 0; c < vecs[i].adv; c++) begin
        limpa_erro = vecs[i].limpa && (c == 0);
        @(posedge clk);
        @(negedge clk);
      end
      limpa_erro = 1'b0;
      check_all($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg,
                vecs[i].ea, vecs[i].er, vecs[i].an1);
    end

    // Reset mid-scan at index 2: outputs clear at once, scan restarts at 0.
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 4'b1111, 7'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_all("restart_r1", 4'b1110, 7'h3F, 1'b0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_all("restart_r4", 4'b1110, 7'h3F, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    check_all("restart_r5", 4'b1101, 7'h3F, 1'b0, 1'b0, 1'b0);
    check("single_seg", 32'(seg1), 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_rega_multi.md
DISPLAY_REGA_MULTI -- requirements
Module: display_rega_multi

Interface
REQ-001 Parameter CANAIS, default 4, number of irrigation channels and display digits, legal range 1..8.
REQ-002 Parameter DIV_VARREDURA, default 50000, clock cycles each digit is lit, minimum 2.
REQ-003 Parameter DIV_PISCA, default 64, complete scan frames per blink half-period, minimum 1.
REQ-004 clk  input  1  single system clock, all state rising-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 gotejamento  input  CANAIS  drip request per channel, asynchronous to clk.
REQ-007 aspersao  input  CANAIS  sprinkler request per channel, asynchronous to clk.
REQ-008 habilita  input  1  display enable, synchronous.
REQ-009 limpa_erro  input  1  single-cycle clear of the sticky error flag, synchronous.
REQ-010 seg  output  7  segments {G,F,E,D,C,B,A}, active-high, registered.
REQ-011 an  output  CANAIS  digit select, active-low one-hot, registered.
REQ-012 erro_ativo  output  1  high while any channel in the current snapshot has both requests set.
REQ-013 erro_retido  output  1  sticky copy of erro_ativo.

Function
REQ-014 Each gotejamento/aspersao bit SHALL pass through a two-flop synchronizer, giving 2 cycles of latency.
REQ-015 Glyph per channel code {gotejamento,aspersao}: 00 nenhum = 0x3F; 10 gotejamento = 0x46; 01 aspersao = 0x08; 11 invalido = 0x40.
REQ-016 Prescaler SHALL count 0..DIV_VARREDURA-1 and wrap, asserting tick on the terminal count.
REQ-017 Digit index SHALL advance on tick, modulo CANAIS, wrapping CANAIS-1 -> 0.
REQ-018 Snapshot register SHALL capture all synchronized channels on the tick at which the index wraps to 0, so that no frame mixes old and new data.
REQ-019 an SHALL drive the bit at the current index low and all other bits high; seg SHALL drive that channel's glyph; both SHALL update one cycle after the index changes.
REQ-020 Frame counter SHALL count index wraps 0..DIV_PISCA-1; fase_pisca SHALL toggle at its terminal count.
REQ-021 An invalid-code digit SHALL show 0x40 when fase_pisca=0 and seg=0x00 when fase_pisca=1; valid codes SHALL never blink.
REQ-022 erro_ativo SHALL be registered as the OR of invalid flags across the snapshot, updated one cycle after each snapshot capture.
REQ-023 erro_retido SHALL be set whenever erro_ativo=1 and cleared by limpa_erro; when set and clear coincide, set wins.
REQ-024 With habilita=0: an all ones; seg=0x00; prescaler, index and frame counter held at 0; snapshot and error logic keep running on every prescaler-independent cycle capture (snapshot captured each cycle).
REQ-025 When habilita rises, the scan SHALL begin at index 0, with the output registers showing digit 0 on the next cycle.
REQ-026 With CANAIS=1, every tick is a wrap, and an[0] SHALL be held low constantly while enabled.

Reset
REQ-027 rst_n low SHALL immediately force: synchronizers 0, snapshot 0, prescaler/index/frame counter 0, fase_pisca 0, an all ones, seg 0x00, erro_ativo 0, erro_retido 0.
REQ-028 Reset asserted mid-scan SHALL abort the scan; after release the scan SHALL restart at index 0 and the first tick SHALL fall DIV_VARREDURA cycles later.

Structure
REQ-029 Package regas_pkg SHALL hold the segment width (7), the 2-bit channel code constants and the four glyph constants.
REQ-030 Sub-module glifo_rega SHALL be the combinational code-plus-blink-phase-to-glyph decoder; the synchronizer, counters and error logic SHALL remain in the top level.

Verification (CANAIS=4, DIV_VARREDURA=4, DIV_PISCA=2)
REQ-031 Reset release with inputs 0, habilita=1 -> an cycles 1110,1101,1011,0111 every 4 clocks, seg=0x3F throughout.
REQ-032 Channel 2 gotejamento=1, channel 1 aspersao=1 -> after the next frame wrap, digit 2 seg=0x46 and digit 1 seg=0x08; the others stay at 0x3F.
REQ-033 Channel 3 both set -> digit 3 alternates between 0x40 and 0x00 every 2 frames (32 clocks); erro_ativo=1 and erro_retido=1.
REQ-034 Remove the invalid code, then pulse limpa_erro -> erro_ativo=0 after the next snapshot, and erro_retido=0 one cycle after the pulse; limpa_erro pulsed while the code is still invalid -> erro_retido stays 1.
REQ-035 Input toggled mid-frame -> displayed value unchanged until the index wraps to 0.
REQ-036 rst_n pulsed low at index 2 -> outputs go to reset values at once, and the scan resumes at index 0 (an=1110).
